// File: rtl/apb_reg_completer.sv
// apb_reg_completer: APB4 completer with a word register file (reg 0 read-only ID, top reg privileged).
// Define APB_COMPLETER_WAIT_EN to insert WAIT_CYCLES wait states per transfer; otherwise zero-wait.
module apb_reg_completer #(
    parameter int DATAWIDTH = 32,
    parameter int ADDRWIDTH = 32,
    parameter int NREGS = 8,
    parameter int WAIT_CYCLES = 2,
    parameter logic [DATAWIDTH-1:0] ID_VALUE = DATAWIDTH'(32'hA5B0_0001)
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         psel,
    input  logic                         penable,
    input  logic                         pwrite,
    input  logic [ADDRWIDTH-1:0]         paddr,
    input  logic [DATAWIDTH-1:0]         pwdata,
    input  logic [DATAWIDTH/8-1:0]       pstrb,
    input  logic [2:0]                   pprot,
    output logic                         pready,
    output logic [DATAWIDTH-1:0]         prdata,
    output logic                         pslverr,
    output logic [NREGS*DATAWIDTH-1:0]   regs_flat
);
    localparam int NB = DATAWIDTH / 8;
    localparam int IW = (NREGS > 1) ? $clog2(NREGS) : 1;
    localparam int XW = ADDRWIDTH - 2;
    typedef enum logic {IDLE, ACCESS} state_t;
    state_t r_state, w_next;
    logic r_write, r_err, w_setup, w_go, w_err, w_unused;
    logic [IW-1:0] r_idx;
    logic [DATAWIDTH-1:0] r_wdata;
    logic [NB-1:0] r_strb;
    logic [XW-1:0] w_idx;
    logic [NREGS-1:1][DATAWIDTH-1:0] r_regs;
`ifdef APB_COMPLETER_WAIT_EN
    logic [3:0] r_cnt;
`endif
    assign w_idx = paddr[ADDRWIDTH-1:2];
    assign w_setup = (r_state == IDLE) && psel && !penable;
    assign w_err = (paddr[1:0] != 2'b00) || (w_idx >= XW'(NREGS)) || (pwrite && w_idx == '0) ||
                   (w_idx == XW'(NREGS - 1) && !pprot[0]);
    assign regs_flat = {r_regs, ID_VALUE};
    assign w_unused = &{1'b0, pprot[2:1], WAIT_CYCLES[0]};
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= IDLE;
            r_write <= 1'b0;
            r_err <= 1'b0;
            r_idx <= '0;
            r_wdata <= '0;
            r_strb <= '0;
`ifdef APB_COMPLETER_WAIT_EN
            r_cnt <= 4'd0;
`endif
        end else begin
            r_state <= w_next;
            if (w_setup) begin
                r_write <= pwrite;
                r_err <= w_err;
                r_idx <= w_idx[IW-1:0];
                r_wdata <= pwdata;
                r_strb <= pstrb;
`ifdef APB_COMPLETER_WAIT_EN
                r_cnt <= 4'(WAIT_CYCLES);
            end else if (w_go && r_cnt != 4'd0) begin
                r_cnt <= r_cnt - 4'd1;
`endif
            end
        end
    end
    // Commit happens on the edge that closes the pready cycle; errored transfers never write
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_regs <= '0;
        end else if (pready && r_write && !r_err) begin
            for (int i = 1; i < NREGS; i++)
                for (int b = 0; b < NB; b++)
                    if (r_idx == IW'(i) && r_strb[b]) r_regs[i][b*8 +: 8] <= r_wdata[b*8 +: 8];
        end
    end
    always_comb begin
        w_go = (r_state == ACCESS) && psel && penable;
`ifdef APB_COMPLETER_WAIT_EN
        pready = w_go && (r_cnt == 4'd0);
`else
        pready = w_go;
`endif
        pslverr = pready && r_err;
        prdata = (pready && !r_write && !r_err) ? regs_flat[r_idx*DATAWIDTH +: DATAWIDTH] : '0;
        w_next = (r_state == IDLE) ? (w_setup ? ACCESS : IDLE) : ((!psel || pready) ? IDLE : ACCESS);
    end
endmodule
